result_writer: RTL and testbench
================================

Name: result_writer

Overview:
- Capture side of the monopulse result path. Stores each `o_result`/`o_valid` word from `monopulse` into an internal RAM.
- On command, streams the stored words out over a valid/ready interface, in arrival order, for off-chip dump (UART/ILA bridge).
- Sits next to `monopulse` in `top`, clocked by the `clk_wiz_0` output clock. Reset is driven from `~locked`.

Parameters:
- DATA_SIZE, 64, operand width of `monopulse`. Stored word width is 2*DATA_SIZE.
- DEPTH, 1024, number of storable results. Must be a power of two, >= 2.
- ADDR_W, $clog2(DEPTH), derived local parameter. Not overridable.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_result  input  2*DATA_SIZE  result word from `monopulse`.
- i_valid  input  1  one-cycle strobe; `i_result` is valid in this cycle.
- i_dump  input  1  pulse; request readout of all stored words.
- o_data  output  2*DATA_SIZE  readout word.
- o_data_valid  output  1  `o_data` is valid.
- i_data_ready  input  1  consumer accepts `o_data` this cycle.
- o_done  output  1  one-cycle pulse after the last readout beat is accepted.
- o_count  output  ADDR_W+1  number of stored words.
- o_full  output  1  buffer holds DEPTH words.
- o_overflow  output  1  sticky flag: at least one `i_valid` was dropped.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (`i_clock`, `i_reset`).
- Reset values: `o_data` = 0, `o_data_valid` = 0, `o_done` = 0, `o_count` = 0, `o_full` = 0, `o_overflow` = 0. State = CAPTURE, write and read pointers = 0.
- RAM: single array, 2*DATA_SIZE x DEPTH. One write port. One registered read port with 1-cycle latency, so it infers BRAM.
- FSM has four states: CAPTURE, FULL, DUMP_FETCH, DUMP_OUT.
- CAPTURE:
  - `i_valid`: write `i_result` at `wr_ptr`, `wr_ptr++`, `o_count++` (visible the next cycle).
  - The write that makes `o_count` = DEPTH moves to FULL and sets `o_full` = 1.
- FULL:
  - `i_valid` is dropped and sets `o_overflow` = 1.
- Dump request (`i_dump` in CAPTURE or FULL):
  - If `i_dump` and `i_valid` arrive in the same CAPTURE cycle, the word is written first and is included in the dump.
  - If the count (after that write) is 0: `o_done` pulses on the next cycle and the state stays CAPTURE.
  - Otherwise: latch `len` = count, set `rd_ptr` = 0, go to DUMP_FETCH.
- DUMP_FETCH: issue a RAM read at `rd_ptr`, then go to DUMP_OUT. The next cycle, `o_data` = mem[`rd_ptr`] and `o_data_valid` = 1.
- DUMP_OUT:
  - Hold `o_data`/`o_data_valid` stable while `i_data_ready` = 0.
  - A beat transfers when valid && ready.
  - On transfer, if beats remain: `rd_ptr++`, back to DUMP_FETCH. This gives at most 1 word per 2 cycles; no prefetch is required.
  - On transfer of the last beat: `o_data_valid` = 0 the next cycle and `o_done` = 1 for exactly that one cycle.
  - In that same cycle `wr_ptr` = 0, `o_count` = 0, `o_full` = 0, and the state returns to CAPTURE.
  - `o_overflow` is also cleared at dump completion.
- `i_valid` during DUMP_FETCH/DUMP_OUT is dropped and sets `o_overflow`. RAM contents under readout are never modified.
- `i_dump` during a dump is ignored.
- `o_data` keeps its last value when not valid. Its content is don't-care while `o_data_valid` = 0.
- Reset mid-dump: all outputs go to their reset values the next cycle. The dump is abandoned and the stored data is discarded (pointers zeroed; RAM contents are not cleared).
- `o_count` never exceeds DEPTH and never wraps.

Decomposition:
- Package `result_writer_pkg`:
  - enum `rw_state_t` {CAPTURE, FULL, DUMP_FETCH, DUMP_OUT}.
  - Default DATA_SIZE/DEPTH constants shared with `top`.
- Sub-module `result_ram`: simple dual-port RAM, 1 write port plus a registered read port, parameterised on width and depth.
- The FSM and pointers stay in `result_writer`.

Test Plan (DATA_SIZE = 8, DEPTH = 4):
1. Reset, 3 `i_valid` pulses with 16'h0011, 16'h0022, 16'h0033, then `i_dump`, ready held at 1:
   - `o_count` = 3 before the dump, `o_full` = 0.
   - Beats arrive in order 0011, 0022, 0033.
   - `o_done` is high exactly one cycle after the 3rd beat; then `o_count` = 0.
2. 5 `i_valid` pulses (0x0A..0x0E):
   - `o_full` = 1 after the 4th pulse, `o_overflow` = 1 after the 5th.
   - The dump yields 0A, 0B, 0C, 0D.
   - After `o_done`: `o_full` = 0, `o_overflow` = 0.
3. `i_dump` with an empty buffer: `o_done` pulses the next cycle, `o_data_valid` is never asserted.
4. Backpressure:
   - Hold ready low for 5 cycles on the first beat: `o_data` stays 0011 and valid stays 1 throughout.
   - Toggle ready afterward: no beat is lost or duplicated.
5. `i_valid` (0x0044) coincident with `i_dump` after 1 stored word (0x0011): the dump yields 0011, 0044. An `i_valid` arriving mid-dump sets `o_overflow` and does not alter the beats.
6. Assert `i_reset` during the 2nd beat:
   - Next cycle: `o_data_valid` = 0, `o_count` = 0, no `o_done` pulse.
   - Fresh capture of 0x0055 followed by a dump yields only 0055.

Source files
------------

// File: rtl/result_writer_pkg.sv
// Purpose: shared types and default sizing for the monopulse result capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package result_writer_pkg;

   // Capture/readout controller states.
   typedef enum logic [1:0] {
      CAPTURE    = 2'd0,
      FULL       = 2'd1,
      DUMP_FETCH = 2'd2,
      DUMP_OUT   = 2'd3
   } rw_state_t;

   // Defaults shared with the integration top.
   localparam int RW_DATA_SIZE = 64;
   localparam int RW_DEPTH     = 1024;

endpackage

// File: rtl/result_ram.sv
// Purpose: simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears one cycle after i_rd_en; it holds while i_rd_en is low.
// Backpressure: none; the caller only issues reads when the consumer can take them.
// Ports: i_clock/i_reset clock and sync reset (clears only the read register),
//        i_wr_en/i_wr_addr/i_wr_data write port, i_rd_en/i_rd_addr read request,
//        o_rd_data registered read word.
module result_ram #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 1024
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [WIDTH-1:0]         o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Array has no reset so the tools can map it onto block RAM.
   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Output register reset maps onto the BRAM output-register reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/result_writer.sv
// Purpose: store monopulse results in RAM, then stream them out in arrival order on request.
// Latency: a write is counted the next cycle; each readout beat takes a fetch cycle plus one output cycle.
// Backpressure: o_data/o_data_valid hold while i_data_ready is low; inputs arriving while full or dumping are dropped and flagged.
// Ports: i_clock/i_reset clock and sync active-high reset; i_result/i_valid capture input;
//        i_dump readout request; o_data/o_data_valid/i_data_ready readout stream;
//        o_done end-of-dump pulse; o_count/o_full/o_overflow buffer status.
module result_writer
   import result_writer_pkg::*;
#(
   parameter int DATA_SIZE = RW_DATA_SIZE,
   parameter int DEPTH     = RW_DEPTH
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [2*DATA_SIZE-1:0]   i_result,
   input  logic                     i_valid,
   input  logic                     i_dump,
   output logic [2*DATA_SIZE-1:0]   o_data,
   output logic                     o_data_valid,
   input  logic                     i_data_ready,
   output logic                     o_done,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_overflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

   rw_state_t         r_state,    w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr,   w_wr_ptr_nxt;
   logic [ADDR_W-1:0] r_rd_ptr,   w_rd_ptr_nxt;
   logic [ADDR_W:0]   r_len,      w_len_nxt;
   logic [ADDR_W:0]   r_count,    w_count_nxt;
   logic              r_full,     w_full_nxt;
   logic              r_overflow, w_overflow_nxt;
   logic              r_done,     w_done_nxt;
   logic              r_dvld,     w_dvld_nxt;
   logic [ADDR_W:0]   w_count_wr;
   logic              w_wr_en;
   logic              w_rd_en;
   logic              w_xfer;

   assign w_xfer = r_dvld & i_data_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= CAPTURE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_len      <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_dvld     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_len      <= w_len_nxt;
         r_count    <= w_count_nxt;
         r_full     <= w_full_nxt;
         r_overflow <= w_overflow_nxt;
         r_done     <= w_done_nxt;
         r_dvld     <= w_dvld_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_len_nxt      = r_len;
      w_count_nxt    = r_count;
      w_full_nxt     = r_full;
      w_overflow_nxt = r_overflow;
      w_done_nxt     = 1'b0;
      w_dvld_nxt     = r_dvld;
      w_count_wr     = r_count;
      w_wr_en        = 1'b0;
      w_rd_en        = 1'b0;

      case (r_state)
         CAPTURE: begin
            if (i_valid) begin
               w_wr_en      = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + 1'b1;
               w_count_wr   = r_count + 1'b1;
               w_count_nxt  = w_count_wr;
               if (w_count_wr == FULL_CNT) begin
                  w_full_nxt  = 1'b1;
                  w_state_nxt = FULL;
               end
            end
            // Dump length uses the post-write count so a coincident word is included.
            if (i_dump) begin
               if (w_count_wr == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_len_nxt    = w_count_wr;
                  w_rd_ptr_nxt = '0;
                  w_state_nxt  = DUMP_FETCH;
               end
            end
         end
         FULL: begin
            if (i_valid) begin
               w_overflow_nxt = 1'b1;
            end
            if (i_dump) begin
               w_len_nxt    = r_count;
               w_rd_ptr_nxt = '0;
               w_state_nxt  = DUMP_FETCH;
            end
         end
         DUMP_FETCH: begin
            if (i_valid) begin
               w_overflow_nxt = 1'b1;
            end
            w_rd_en     = 1'b1;
            w_dvld_nxt  = 1'b1;
            w_state_nxt = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (i_valid) begin
               w_overflow_nxt = 1'b1;
            end
            if (w_xfer) begin
               w_dvld_nxt = 1'b0;
               if ({1'b0, r_rd_ptr} == r_len - 1'b1) begin
                  // Completion empties the buffer; its clear wins over a same-cycle drop.
                  w_done_nxt     = 1'b1;
                  w_wr_ptr_nxt   = '0;
                  w_count_nxt    = '0;
                  w_full_nxt     = 1'b0;
                  w_overflow_nxt = 1'b0;
                  w_state_nxt    = CAPTURE;
               end else begin
                  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                  w_state_nxt  = DUMP_FETCH;
               end
            end
         end
         default: begin
            w_state_nxt = CAPTURE;
         end
      endcase
   end

   result_ram #(
      .WIDTH (2*DATA_SIZE),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_result),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (o_data)
   );

   assign o_data_valid = r_dvld;
   assign o_done       = r_done;
   assign o_count      = r_count;
   assign o_full       = r_full;
   assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_result_writer.sv
// Purpose: self-checking bench for result_writer with a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_result_writer;

   localparam int DS = 8;
   localparam int DP = 4;
   localparam int W  = 2*DS;

   logic          clk = 1'b0;
   logic          i_reset;
   logic [W-1:0]  i_result;
   logic          i_valid;
   logic          i_dump;
   logic [W-1:0]  o_data;
   logic          o_data_valid;
   logic          i_data_ready;
   logic          o_done;
   logic [2:0]    o_count;
   logic          o_full;
   logic          o_overflow;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: stored words in arrival order plus the sticky drop flag.
   logic [W-1:0] m_q [$];
   bit           m_ovf;

   always #5 clk = ~clk;

   result_writer #(.DATA_SIZE(DS), .DEPTH(DP)) dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_result     (i_result),
      .i_valid      (i_valid),
      .i_dump       (i_dump),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .i_data_ready (i_data_ready),
      .o_done       (o_done),
      .o_count      (o_count),
      .o_full       (o_full),
      .o_overflow   (o_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_count"}, 32'(o_count), 32'(m_q.size()));
      chk({tag, "_full"},  32'(o_full),  32'(m_q.size() == DP));
      chk({tag, "_ovf"},   32'(o_overflow), 32'(m_ovf));
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic cap(input logic [W-1:0] w);
      i_valid  = 1'b1;
      i_result = w;
      if (m_q.size() < DP) m_q.push_back(w);
      else                 m_ovf = 1'b1;
      tick();
      i_valid = 1'b0;
      chk_status("cap");
   endtask

   // mode 0: ready always high; 1: random ready; 2: stall first beat 5 cycles, then toggle.
   task automatic run_dump(input int mode, input bit inj, input bit with_valid, input logic [W-1:0] vword);
      logic [W-1:0] exp_q [$];
      logic [W-1:0] prev;
      bit  prev_hold, finished, injected, rdy, xfer;
      int  got, cyc, stall;
      prev_hold = 0; finished = 0; injected = 0; got = 0; cyc = 0; stall = 0; prev = '0;
      i_dump  = 1'b1;
      i_valid = with_valid;
      i_result = vword;
      if (with_valid) begin
         if (m_q.size() < DP) m_q.push_back(vword);
         else                 m_ovf = 1'b1;
      end
      exp_q = m_q;
      tick();
      i_dump  = 1'b0;
      i_valid = 1'b0;
      if (exp_q.size() == 0) begin
         chk("empty_done", 32'(o_done), 32'd1);
         chk("empty_vld",  32'(o_data_valid), 32'd0);
         tick();
         chk("empty_done_end", 32'(o_done), 32'd0);
         chk("empty_vld_end",  32'(o_data_valid), 32'd0);
         return;
      end
      while (!finished && cyc < 200) begin
         if (prev_hold) begin
            chk("hold_vld", 32'(o_data_valid), 32'd1);
            chk("hold_dat", 32'(o_data), 32'(prev));
         end
         chk("done_mid", 32'(o_done), 32'd0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (got == 0 && stall < 5) ? 1'b0 : (cyc % 2 == 0);
         endcase
         if (mode == 2 && got == 0 && o_data_valid && !rdy) stall++;
         i_data_ready = rdy;
         if (inj && !injected && got == 1 && !o_data_valid) begin
            i_valid  = 1'b1;
            i_result = 16'hBEEF;
            m_ovf    = 1'b1;
            injected = 1'b1;
         end
         xfer = o_data_valid && rdy;
         if (xfer) begin
            chk("beat", 32'(o_data), 32'(exp_q[got]));
            got++;
         end
         prev_hold = o_data_valid && !rdy;
         prev = o_data;
         tick();
         if (i_valid) begin
            i_valid = 1'b0;
            chk("ovf_mid", 32'(o_overflow), 32'd1);
         end
         cyc++;
         if (xfer && got == exp_q.size()) begin
            finished = 1'b1;
            chk("end_done",  32'(o_done), 32'd1);
            chk("end_vld",   32'(o_data_valid), 32'd0);
            chk("end_count", 32'(o_count), 32'd0);
            chk("end_full",  32'(o_full), 32'd0);
            chk("end_ovf",   32'(o_overflow), 32'd0);
            tick();
            chk("done_pulse", 32'(o_done), 32'd0);
         end
      end
      i_data_ready = 1'b1;
      m_q.delete();
      m_ovf = 1'b0;
      if (!finished) begin
         chk("dump_timeout", 32'd0, 32'd1);
         do_reset();
      end
   endtask

   initial begin
      int waits;
      i_reset = 1'b0; i_result = '0; i_valid = 1'b0; i_dump = 1'b0; i_data_ready = 1'b1;
      do_reset();
      chk("rst_data",  32'(o_data), 32'd0);
      chk("rst_vld",   32'(o_data_valid), 32'd0);
      chk("rst_done",  32'(o_done), 32'd0);
      chk_status("rst");

      // In-order readout of a partial buffer.
      cap(16'h0011); cap(16'h0022); cap(16'h0033);
      run_dump(0, 0, 0, '0);

      // Fill past capacity; the fifth word is dropped and flagged.
      for (int k = 0; k < 5; k++) cap(16'(8'h0A + k));
      run_dump(0, 0, 0, '0);

      // Empty dump.
      run_dump(0, 0, 0, '0);

      // Backpressure on the first beat, then toggling ready.
      cap(16'h0011); cap(16'h0022); cap(16'h0033);
      run_dump(2, 0, 0, '0);

      // Coincident capture and dump, plus a drop during readout.
      cap(16'h0011);
      run_dump(0, 1, 1, 16'h0044);

      // Reset during the second beat.
      cap(16'h0011); cap(16'h0022);
      i_dump = 1'b1; tick(); i_dump = 1'b0;
      waits = 0;
      while (!o_data_valid && waits < 10) begin tick(); waits++; end
      tick();
      waits = 0;
      while (!o_data_valid && waits < 10) begin tick(); waits++; end
      chk("beat2_seen", 32'(o_data_valid), 32'd1);
      i_data_ready = 1'b0;
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      i_data_ready = 1'b1;
      m_q.delete(); m_ovf = 1'b0;
      chk("midrst_vld",   32'(o_data_valid), 32'd0);
      chk("midrst_done",  32'(o_done), 32'd0);
      chk_status("midrst");
      tick();
      chk("midrst_done2", 32'(o_done), 32'd0);
      cap(16'h0055);
      run_dump(0, 0, 0, '0);

      // Randomized rounds.
      for (int r = 0; r < 30; r++) begin
         int n;
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) cap(16'($urandom));
         run_dump($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
